// File: rtl/fir_mac_filter.sv
// Time-multiplexed FIR: one MAC per tap over a circular delay line, rounded and clamped to DW bits.
// Latency NTAPS+1 cycles from accepted sample to filtered_valid; samples arriving while busy are dropped and flag overrun.
module fir_mac_filter #(
   parameter int NTAPS = 31,
   parameter int DW    = 10,
   parameter int CW    = 12,
   parameter int ACCW  = 28
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          sample_valid,
   input  logic [DW-1:0] sample,
   input  logic          coef_we,
   input  logic [4:0]    coef_addr,
   input  logic [CW-1:0] coef_data,
   output logic [DW-1:0] filtered,
   output logic          filtered_valid,
   output logic          busy,
   output logic          overrun
);

   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

   localparam logic [4:0]             LAST     = 5'(NTAPS - 1);
   localparam logic signed [CW-1:0]   COEF_ONE = {2'b01, {(CW-2){1'b0}}};
   localparam logic signed [ACCW-1:0] HALF     = {{(ACCW-CW+2){1'b0}}, 1'b1, {(CW-3){1'b0}}};

   state_t                 state_q, state_d;
   logic [4:0]             k_q, k_d;
   logic [4:0]             rd_q, rd_d;
   logic [4:0]             wr_ptr_q, wr_ptr_d;
   logic signed [ACCW-1:0] acc_q, acc_d;
   logic [DW-1:0]          filtered_q, filtered_d;
   logic                   filtered_valid_q, filtered_valid_d;
   logic                   overrun_q, overrun_d;

   logic [DW-1:0]          dline_q [NTAPS];
   logic signed [CW-1:0]   coef_q  [NTAPS];

   logic                   dline_we;
   logic                   coef_wr;
   logic signed [CW+DW:0]  prod;
   logic signed [ACCW-1:0] rnd;

   always_comb begin
      state_d          = state_q;
      k_d              = k_q;
      rd_d             = rd_q;
      wr_ptr_d         = wr_ptr_q;
      acc_d            = acc_q;
      filtered_d       = filtered_q;
      filtered_valid_d = 1'b0;
      overrun_d        = overrun_q;
      dline_we         = 1'b0;
      coef_wr          = 1'b0;

      prod = coef_q[k_q] * $signed({1'b0, dline_q[rd_q]});
      rnd  = (acc_q + HALF) >>> (CW - 2);

      if (sample_valid && (state_q != IDLE)) begin
         overrun_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            coef_wr = coef_we && ({1'b0, coef_addr} < 6'(NTAPS));
            if (sample_valid) begin
               dline_we = 1'b1;
               k_d      = '0;
               rd_d     = wr_ptr_q;
               acc_d    = '0;
               state_d  = MAC;
            end
         end
         MAC: begin
            acc_d = acc_q + $signed({{(ACCW-CW-DW-1){prod[CW+DW]}}, prod});
            k_d   = k_q + 5'd1;
            // Walk backwards through the delay line, wrapping at NTAPS rather than 32
            rd_d  = (rd_q == 5'd0) ? LAST : rd_q - 5'd1;
            if (k_q == LAST) begin
               state_d = OUT;
            end
         end
         OUT: begin
            if (rnd[ACCW-1]) begin
               filtered_d = '0;
            end else if (|rnd[ACCW-2:DW]) begin
               filtered_d = '1;
            end else begin
               filtered_d = rnd[DW-1:0];
            end
            filtered_valid_d = 1'b1;
            wr_ptr_d         = (wr_ptr_q == LAST) ? 5'd0 : wr_ptr_q + 5'd1;
            state_d          = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q          <= IDLE;
         k_q              <= '0;
         rd_q             <= '0;
         wr_ptr_q         <= '0;
         acc_q            <= '0;
         filtered_q       <= '0;
         filtered_valid_q <= 1'b0;
         overrun_q        <= 1'b0;
         for (int i = 0; i < NTAPS; i++) begin
            dline_q[i] <= '0;
            coef_q[i]  <= (i == 0) ? COEF_ONE : '0;
         end
      end else begin
         state_q          <= state_d;
         k_q              <= k_d;
         rd_q             <= rd_d;
         wr_ptr_q         <= wr_ptr_d;
         acc_q            <= acc_d;
         filtered_q       <= filtered_d;
         filtered_valid_q <= filtered_valid_d;
         overrun_q        <= overrun_d;
         if (dline_we) begin
            dline_q[wr_ptr_q] <= sample;
         end
         if (coef_wr) begin
            coef_q[coef_addr] <= coef_data;
         end
      end
   end

   assign filtered       = filtered_q;
   assign filtered_valid = filtered_valid_q;
   assign busy           = (state_q != IDLE);
   assign overrun        = overrun_q;

endmodule

// File: tb/tb_fir_mac_filter.sv
// Bench for fir_mac_filter: directed spec vectors plus random samples/coefficients vs a convolution model.
module tb_fir_mac_filter;

   localparam int NTAPS = 31;
   localparam int DW    = 10;
   localparam int CW    = 12;
   localparam int ACCW  = 28;

   logic          clk = 1'b0;
   logic          reset;
   logic          sample_valid;
   logic [DW-1:0] sample;
   logic          coef_we;
   logic [4:0]    coef_addr;
   logic [CW-1:0] coef_data;
   logic [DW-1:0] filtered;
   logic          filtered_valid;
   logic          busy;
   logic          overrun;

   int tests  = 0;
   int failed = 0;

   int coef_m [NTAPS];
   int hist [$];

   fir_mac_filter #(.NTAPS(NTAPS), .DW(DW), .CW(CW), .ACCW(ACCW)) dut (
      .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample(sample),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
      .filtered(filtered), .filtered_valid(filtered_valid), .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Direct-form convolution over the accepted history, then round half up and clamp
   function automatic int model_out();
      longint acc = 0;
      longint r;
      for (int k = 0; k < NTAPS; k++) begin
         if (k < hist.size()) acc += longint'(coef_m[k]) * longint'(hist[hist.size() - 1 - k]);
      end
      r = (acc + (64'sd1 <<< (CW - 3))) >>> (CW - 2);
      if (r < 0) r = 0;
      if (r > (1 << DW) - 1) r = (1 << DW) - 1;
      return int'(r);
   endfunction

   function automatic void model_reset();
      hist.delete();
      for (int k = 0; k < NTAPS; k++) coef_m[k] = 0;
      coef_m[0] = 1 << (CW - 2);
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic wr_coef(input int k, input int v);
      @(negedge clk);
      coef_we   = 1'b1;
      coef_addr = 5'(k);
      coef_data = CW'(v);
      @(negedge clk);
      coef_we = 1'b0;
      if (k < NTAPS) coef_m[k] = v;
   endtask

   // intr: 0 none, 1 extra sample_valid at E0+5, 2 coef write (tap 30 := 0) at E0+5
   task automatic run_sample(input int x, input int lit, input int intr,
                             input bit sim_we = 1'b0, input int sim_addr = 0, input int sim_data = 0);
      int  exp;
      bit  early = 1'b0;
      @(negedge clk);
      sample_valid = 1'b1;
      sample       = DW'(x);
      if (sim_we) begin
         coef_we   = 1'b1;
         coef_addr = 5'(sim_addr);
         coef_data = CW'(sim_data);
      end
      @(negedge clk);
      sample_valid = 1'b0;
      coef_we      = 1'b0;
      if (sim_we && sim_addr < NTAPS) coef_m[sim_addr] = sim_data;
      hist.push_back(x);
      if (hist.size() > NTAPS) void'(hist.pop_front());
      exp = model_out();
      chk("busy_in_mac", busy, 1);
      for (int j = 1; j <= NTAPS; j++) begin
         if (j == 5 && intr == 1) begin
            sample_valid = 1'b1;
            sample       = DW'(555);
         end
         if (j == 5 && intr == 2) begin
            coef_we   = 1'b1;
            coef_addr = 5'd30;
            coef_data = '0;
         end
         @(negedge clk);
         sample_valid = 1'b0;
         coef_we      = 1'b0;
         early        = early | filtered_valid;
      end
      chk("no_early_valid", early, 0);
      @(negedge clk);
      chk("valid_at_latency", filtered_valid, 1);
      chk("filtered_model", filtered, exp);
      if (lit >= 0) chk("filtered_literal", filtered, lit);
      chk("busy_after_out", busy, 0);
      @(negedge clk);
      chk("valid_one_cycle", filtered_valid, 0);
      chk("filtered_held", filtered, exp);
   endtask

   initial begin
      bit seen;
      reset        = 1'b1;
      sample_valid = 1'b0;
      sample       = '0;
      coef_we      = 1'b0;
      coef_addr    = '0;
      coef_data    = '0;
      model_reset();
      #3;
      chk("rst_filtered", filtered, 0);
      chk("rst_valid", filtered_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);
      @(negedge clk);
      reset = 1'b0;

      // Pass-through with default coefficients
      run_sample(300, 300, 0);
      chk("pass_overrun", overrun, 0);

      // Four-tap moving average
      do_reset();
      for (int k = 0; k < 4; k++) wr_coef(k, 256);
      run_sample(0, 0, 0);
      run_sample(800, 200, 0);
      run_sample(800, 400, 0);
      run_sample(800, 600, 0);
      run_sample(800, 800, 0);

      // Saturation at both rails
      do_reset();
      wr_coef(0, 2047);
      run_sample(1000, 1023, 0);
      wr_coef(0, -1024);
      run_sample(500, 0, 0);

      // Overrun: second strobe mid-computation is dropped, flag sticks
      do_reset();
      run_sample(100, 100, 1);
      chk("overrun_set", overrun, 1);
      seen = 1'b0;
      repeat (NTAPS + 5) begin
         @(negedge clk);
         seen = seen | filtered_valid;
      end
      chk("overrun_no_second_out", seen, 0);
      run_sample(200, 200, 0);
      chk("overrun_sticky", overrun, 1);

      // Reset in the middle of MAC
      do_reset();
      chk("overrun_cleared", overrun, 0);
      wr_coef(0, 512);
      run_sample(300, 150, 0);
      @(negedge clk);
      sample_valid = 1'b1;
      sample       = DW'(400);
      @(negedge clk);
      sample_valid = 1'b0;
      repeat (10) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("midmac_filtered", filtered, 0);
      chk("midmac_busy", busy, 0);
      chk("midmac_valid", filtered_valid, 0);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      seen = 1'b0;
      repeat (NTAPS + 5) begin
         @(negedge clk);
         seen = seen | filtered_valid;
      end
      chk("midmac_no_pulse", seen, 0);
      run_sample(300, 300, 0);

      // Delay-line wrap: only the oldest tap contributes; busy writes and bad addresses ignored
      do_reset();
      wr_coef(0, 0);
      wr_coef(30, 1024);
      wr_coef(31, 700);
      for (int n = 1; n <= 40; n++) begin
         run_sample(n, (n > 30) ? n - 30 : 0, (n % 7 == 0) ? 2 : 0);
      end

      // Random coefficients and samples, with occasional same-edge coefficient writes
      do_reset();
      for (int k = 0; k < NTAPS; k++) wr_coef(k, int'($urandom_range(0, 300)) - 120);
      for (int i = 0; i < 40; i++) begin
         bit sw;
         sw = ($urandom_range(0, 3) == 0);
         run_sample(int'($urandom_range(0, 1023)), -1, 0, sw,
                    int'($urandom_range(0, 31)), int'($urandom_range(0, 4095)) - 2048);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
